// File: rtl/pid_pkg.sv
// Shared types, constants and helpers for the PID update sequencer.
package pid_pkg;

  localparam int PID_ACC_W = 16;

  // One state per arithmetic step; each state uses the shared adder once
  typedef enum logic [2:0] {
    IDLE,
    ERR,
    INT,
    DER,
    SUM1,
    SUM2
  } state_e;

  // Adder operand A sources
  typedef enum logic [2:0] {
    OPA_SP,
    OPA_I,
    OPA_E,
    OPA_E_KP,
    OPA_Y
  } opa_e;

  // Adder operand B sources
  typedef enum logic [2:0] {
    OPB_MEAS,
    OPB_E,
    OPB_EPREV,
    OPB_I_KI,
    OPB_D_KD
  } opb_e;

  // Widen an unsigned 8-bit pin value into a non-negative signed operand
  function automatic logic signed [31:0] sext8(input logic [7:0] v);
    return $signed({24'd0, v});
  endfunction

  // Saturate a signed value to the unsigned 0..255 output range
  function automatic logic [7:0] sat_u8(input logic signed [31:0] v);
    if (v < 0)
      return 8'd0;
    else if (v > 255)
      return 8'hFF;
    else
      return v[7:0];
  endfunction

endpackage

// File: rtl/pid_addsub.sv
// Single shared adder/subtractor used by every arithmetic step of a sample.
module pid_addsub #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] i_a,
  input  logic signed [W-1:0] i_b,
  input  logic                i_sub,
  output logic signed [W-1:0] o_sum
);

  // Add or subtract the two operands selected by the sequencer
  always_comb begin
    if (i_sub)
      o_sum = i_a - i_b;
    else
      o_sum = i_a + i_b;
  end

endmodule

// File: rtl/pid_sequencer.sv
// Multi-cycle PID controller: one sample is processed over five steps that
// all share a single adder, producing a saturated 8-bit control value.
module pid_sequencer
  import pid_pkg::*;
#(
  parameter int ACC_W = PID_ACC_W,
  parameter int I_LIM = 2000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic                    i_clear_int,
  input  logic [7:0]              i_setpoint,
  input  logic [7:0]              i_measurement,
  input  logic [2:0]              i_kp_sh,
  input  logic [2:0]              i_ki_sh,
  input  logic [2:0]              i_kd_sh,
  output logic [7:0]              o_ctrl_out,
  output logic                    o_done,
  output logic                    o_busy,
  output logic signed [ACC_W-1:0] o_integ
);

  localparam logic signed [ACC_W-1:0] LIM_P = ACC_W'(I_LIM);
  localparam logic signed [ACC_W-1:0] LIM_N = -LIM_P;

  state_e r_state;
  state_e w_nextState;

  logic [7:0]              r_sp;
  logic [7:0]              r_meas;
  logic signed [ACC_W-1:0] r_e;
  logic signed [ACC_W-1:0] r_i;
  logic signed [ACC_W-1:0] r_eprev;
  logic signed [ACC_W-1:0] r_d;
  logic signed [ACC_W-1:0] r_y;
  logic [7:0]              r_ctrl;
  logic                    r_done;

  opa_e                    w_selA;
  opb_e                    w_selB;
  logic                    w_sub;
  logic                    w_busy;
  logic signed [ACC_W-1:0] w_opA;
  logic signed [ACC_W-1:0] w_opB;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_eKp;
  logic signed [ACC_W-1:0] w_iKi;
  logic signed [ACC_W-1:0] w_dKd;
  logic signed [ACC_W-1:0] w_intClamped;

  // Gain shifts are arithmetic so negative terms round toward minus infinity
  assign w_eKp = r_e >>> i_kp_sh;
  assign w_iKi = r_i >>> i_ki_sh;
  assign w_dKd = r_d >>> i_kd_sh;

  // State register; reset abandons any sample in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_nextState;
  end

  // Next state: a fixed walk through the five arithmetic steps
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE:    if (i_start) w_nextState = ERR;
      ERR:     w_nextState = INT;
      INT:     w_nextState = DER;
      DER:     w_nextState = SUM1;
      SUM1:    w_nextState = SUM2;
      SUM2:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Per-state adder operand selection and busy flag
  always_comb begin
    w_busy = 1'b1;
    w_selA = OPA_SP;
    w_selB = OPB_MEAS;
    w_sub  = 1'b0;
    unique case (r_state)
      IDLE: w_busy = 1'b0;
      ERR:  w_sub  = 1'b1;
      INT: begin
        w_selA = OPA_I;
        w_selB = OPB_E;
      end
      DER: begin
        w_selA = OPA_E;
        w_selB = OPB_EPREV;
        w_sub  = 1'b1;
      end
      SUM1: begin
        w_selA = OPA_E_KP;
        w_selB = OPB_I_KI;
      end
      SUM2: begin
        w_selA = OPA_Y;
        w_selB = OPB_D_KD;
      end
      default: w_busy = 1'b0;
    endcase
  end

  // Operand A mux feeding the shared adder
  always_comb begin
    w_opA = '0;
    unique case (w_selA)
      OPA_SP:   w_opA = ACC_W'(sext8(r_sp));
      OPA_I:    w_opA = r_i;
      OPA_E:    w_opA = r_e;
      OPA_E_KP: w_opA = w_eKp;
      OPA_Y:    w_opA = r_y;
      default:  w_opA = '0;
    endcase
  end

  // Operand B mux feeding the shared adder
  always_comb begin
    w_opB = '0;
    unique case (w_selB)
      OPB_MEAS:  w_opB = ACC_W'(sext8(r_meas));
      OPB_E:     w_opB = r_e;
      OPB_EPREV: w_opB = r_eprev;
      OPB_I_KI:  w_opB = w_iKi;
      OPB_D_KD:  w_opB = w_dKd;
      default:   w_opB = '0;
    endcase
  end

  pid_addsub #(
    .W(ACC_W)
  ) u_addsub (
    .i_a   (w_opA),
    .i_b   (w_opB),
    .i_sub (w_sub),
    .o_sum (w_sum)
  );

  // Integrator limit is a comparator on the adder result, not extra adder work
  always_comb begin
    if (w_sum > LIM_P)
      w_intClamped = LIM_P;
    else if (w_sum < LIM_N)
      w_intClamped = LIM_N;
    else
      w_intClamped = w_sum;
  end

  // Datapath registers: each state captures the adder result it produced
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sp    <= '0;
      r_meas  <= '0;
      r_e     <= '0;
      r_i     <= '0;
      r_eprev <= '0;
      r_d     <= '0;
      r_y     <= '0;
      r_ctrl  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= (r_state == SUM2);
      unique case (r_state)
        IDLE: begin
          if (i_clear_int) begin
            r_i     <= '0;
            r_eprev <= '0;
          end
          if (i_start) begin
            r_sp   <= i_setpoint;
            r_meas <= i_measurement;
          end
        end
        ERR:  r_e <= w_sum;
        INT:  r_i <= w_intClamped;
        DER: begin
          r_d     <= w_sum;
          r_eprev <= r_e;
        end
        SUM1: r_y <= w_sum;
        SUM2: r_ctrl <= sat_u8(32'(w_sum));
        default: ;
      endcase
    end
  end

  assign o_ctrl_out = r_ctrl;
  assign o_done     = r_done;
  assign o_busy     = w_busy;
  assign o_integ    = r_i;

endmodule

// File: tb/tb_pid_sequencer.sv
// Scoreboard bench for pid_sequencer: a behavioural model predicts each
// sample's result at accept time; a monitor checks it when done pulses.
module tb_pid_sequencer;

  localparam int ACC_W = 16;
  localparam int I_LIM = 2000;
  localparam int LATENCY = 5;

  logic                    clk;
  logic                    rst;
  logic                    start;
  logic                    clearInt;
  logic [7:0]              setpoint;
  logic [7:0]              measurement;
  logic [2:0]              kpSh;
  logic [2:0]              kiSh;
  logic [2:0]              kdSh;
  logic [7:0]              ctrlOut;
  logic                    done;
  logic                    busy;
  logic signed [ACC_W-1:0] integ;

  typedef struct {
    int ctrl;
    int integ;
    int cyc;
  } exp_t;

  exp_t sbQ[$];
  int testsRun = 0;
  int testsFailed = 0;
  int cyc = 0;
  int mBusy = 0;
  int mI = 0;
  int mEprev = 0;

  pid_sequencer #(
    .ACC_W(ACC_W),
    .I_LIM(I_LIM)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (start),
    .i_clear_int   (clearInt),
    .i_setpoint    (setpoint),
    .i_measurement (measurement),
    .i_kp_sh       (kpSh),
    .i_ki_sh       (kiSh),
    .i_kd_sh       (kdSh),
    .o_ctrl_out    (ctrlOut),
    .o_done        (done),
    .o_busy        (busy),
    .o_integ       (integ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Division by 2^s rounded toward minus infinity
  function automatic int floorShift(int x, int s);
    int p;
    p = 1 << s;
    if (x >= 0)
      return x / p;
    return -((-x + p - 1) / p);
  endfunction

  // Record one comparison
  task automatic checkOutput(string name, int actual, int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference model: decides acceptance and predicts the sample result
  always @(posedge clk) begin
    if (!rst) begin
      int e;
      int d;
      int y;
      exp_t item;
      cyc++;
      if (mBusy > 0) begin
        mBusy--;
      end else begin
        if (clearInt) begin
          mI = 0;
          mEprev = 0;
        end
        if (start) begin
          e = int'(setpoint) - int'(measurement);
          mI = mI + e;
          if (mI > I_LIM) mI = I_LIM;
          if (mI < -I_LIM) mI = -I_LIM;
          d = e - mEprev;
          mEprev = e;
          y = floorShift(e, kpSh) + floorShift(mI, kiSh) + floorShift(d, kdSh);
          item.ctrl = (y < 0) ? 0 : (y > 255) ? 255 : y;
          item.integ = mI;
          item.cyc = cyc + LATENCY;
          sbQ.push_back(item);
          mBusy = LATENCY;
        end
      end
    end
  end

  // Monitor: checks busy every cycle and each result when done pulses
  always @(negedge clk) begin
    if (!rst) begin
      exp_t item;
      checkOutput("busy", int'(busy), (mBusy > 0) ? 1 : 0);
      if (done) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          item = sbQ.pop_front();
          checkOutput("done_latency", cyc, item.cyc);
          checkOutput("ctrl_out", int'(ctrlOut), item.ctrl);
          checkOutput("integ", int'(integ), item.integ);
        end
      end else if (sbQ.size() > 0 && sbQ[0].cyc <= cyc) begin
        item = sbQ.pop_front();
        checkOutput("missing_done", 0, 1);
      end
    end
  end

  // Issue one start once the controller is idle, with the given inputs
  task automatic applyStimulus(int sp, int meas, int kp, int ki, int kd, bit clr);
    int guard;
    guard = 0;
    while (mBusy != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (mBusy != 0) checkOutput("idle_timeout", mBusy, 0);
    setpoint    = 8'(sp);
    measurement = 8'(meas);
    kpSh        = 3'(kp);
    kiSh        = 3'(ki);
    kdSh        = 3'(kd);
    clearInt    = clr;
    start       = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    clearInt = 1'b0;
  endtask

  // Wait until every predicted result has been observed
  task automatic waitDrain();
    int guard;
    guard = 0;
    while (sbQ.size() != 0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (sbQ.size() != 0) begin
      checkOutput("drain_timeout", sbQ.size(), 0);
      sbQ.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    clearInt = 1'b0;
    setpoint = 8'd0;
    measurement = 8'd0;
    kpSh = 3'd0;
    kiSh = 3'd0;
    kdSh = 3'd0;
    repeat (2) @(negedge clk);
    checkOutput("reset_ctrl", int'(ctrlOut), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_integ", int'(integ), 0);
    rst = 1'b0;
    @(negedge clk);

    // Reset asserted while the sample sits in SUM1
    applyStimulus(150, 20, 0, 0, 0, 1'b0);
    begin
      int guard;
      guard = 0;
      while (mBusy != 2 && guard < 10) begin
        @(negedge clk);
        guard++;
      end
    end
    #1 rst = 1'b1;
    sbQ.delete();
    mBusy = 0;
    mI = 0;
    mEprev = 0;
    #1;
    checkOutput("async_rst_ctrl", int'(ctrlOut), 0);
    checkOutput("async_rst_done", int'(done), 0);
    checkOutput("async_rst_busy", int'(busy), 0);
    checkOutput("async_rst_integ", int'(integ), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(30, 10, 0, 0, 0, 1'b0);
    waitDrain();

    // Pure integral path with high damping on I and D
    applyStimulus(100, 40, 0, 7, 7, 1'b1);
    waitDrain();
    checkOutput("t2_ctrl", int'(ctrlOut), 60);
    checkOutput("t2_integ", int'(integ), 60);

    // Integrator wind-up to the clamp with start held high
    setpoint = 8'd200;
    measurement = 8'd0;
    kpSh = 3'd7;
    kiSh = 3'd0;
    kdSh = 3'd7;
    clearInt = 1'b1;
    start = 1'b1;
    @(negedge clk);
    clearInt = 1'b0;
    repeat (60) @(negedge clk);
    start = 1'b0;
    waitDrain();
    checkOutput("t3_integ_clamped", int'(integ), 2000);
    checkOutput("t3_ctrl", int'(ctrlOut), 255);

    // Negative error saturates the output low
    applyStimulus(0, 200, 0, 7, 7, 1'b1);
    waitDrain();
    checkOutput("t4_integ", int'(integ), -200);
    checkOutput("t4_ctrl", int'(ctrlOut), 0);

    // Derivative kick, then clear together with start
    applyStimulus(50, 0, 7, 7, 0, 1'b1);
    applyStimulus(50, 50, 7, 7, 0, 1'b0);
    waitDrain();
    checkOutput("t5_ctrl_neg_d", int'(ctrlOut), 0);
    applyStimulus(10, 0, 7, 7, 0, 1'b1);
    waitDrain();
    checkOutput("t5_integ", int'(integ), 10);
    checkOutput("t5_ctrl", int'(ctrlOut), 10);

    // Start pulses while busy are ignored
    applyStimulus(90, 30, 1, 2, 3, 1'b0);
    setpoint = 8'd5;
    for (int k = 0; k < 4; k++) begin
      start = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    waitDrain();

    // Start held high continuously: one result every six cycles
    setpoint = 8'd120;
    measurement = 8'd100;
    start = 1'b1;
    repeat (30) @(negedge clk);
    start = 1'b0;
    waitDrain();

    // Randomized samples with random gains and occasional clears
    for (int n = 0; n < 150; n++) begin
      applyStimulus($urandom_range(255), $urandom_range(255), $urandom_range(7),
                    $urandom_range(7), $urandom_range(7), ($urandom_range(7) == 0));
    end
    waitDrain();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
